led_seq_ctrl: RTL and testbench

//  Top-level sequencer for the 18-LED driver. Starts each pattern stage (states1..statesN) in turn.

---
 rtl/led_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: steps the LED pattern stages in order, muxes the active
// stage onto the LED pins and supervises each stage with a cycle watchdog.
//
// Ports:
//   clk        rising-edge system clock
//   sync_rs    synchronous active-high reset
//   run        1 = run the sequence, 0 = abort to idle
//   loop_en    1 = wrap last stage to stage 0, 0 = stop after one pass
//   st_over    per-stage over flags (bit i = stage i)
//   st_out     stage patterns, stage i at [i*LED_W +: LED_W]
//   st_begin   one-hot begin line to the active stage
//   enabler    shared stage enable, high only while sequencing
//   led        registered LED drive
//   cur_st     active stage index (0 when not sequencing)
//   pass_done  one-cycle pulse on the last-stage handoff
//   fault      sticky watchdog-expiry flag
module led_seq_ctrl #(
    parameter int                NUM_ST   = 4,
    parameter int                LED_W    = 18,
    parameter int                TIMEOUT  = 1024,
    parameter logic [LED_W-1:0]  LED_IDLE = '0
) (
    input  logic                     clk,
    input  logic                     sync_rs,
    input  logic                     run,
    input  logic                     loop_en,
    input  logic [NUM_ST-1:0]        st_over,
    input  logic [NUM_ST*LED_W-1:0]  st_out,
    output logic [NUM_ST-1:0]        st_begin,
    output logic                     enabler,
    output logic [LED_W-1:0]         led,
    output logic [2:0]               cur_st,
    output logic                     pass_done,
    output logic                     fault
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
    localparam logic [2:0] LAST = 3'(NUM_ST - 1);
    localparam logic [NUM_ST-1:0] ONE = NUM_ST'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [2:0]          r_idx;
    logic [WD_W-1:0]     r_wdog;
    logic [NUM_ST-1:0]   r_begin;
    logic                r_enabler;
    logic [LED_W-1:0]    r_led;
    logic [2:0]          r_cur;
    logic                r_pass_done;
    logic                r_fault;

    logic [7:0]          w_over_ext;
    logic                w_over;
    logic                w_exp;
    logic                w_hand;
    logic [2:0]          w_nidx;
    logic [LED_W-1:0]    w_slice;

    // Only the active stage's over flag is looked at.
    always_comb begin
        w_over_ext = 8'(st_over);
        w_over     = w_over_ext[r_idx];
        w_exp      = (r_wdog == WD_MAX);
        w_hand     = w_over | w_exp;
        w_nidx     = r_idx + 3'd1;
        w_slice    = LED_IDLE;
        for (int i = 0; i < NUM_ST; i++) begin
            if (r_idx == 3'(i)) begin
                w_slice = st_out[i*LED_W +: LED_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rs) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_wdog      <= '0;
            r_begin     <= '0;
            r_enabler   <= 1'b0;
            r_led       <= LED_IDLE;
            r_cur       <= '0;
            r_pass_done <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_pass_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state   <= S_ACTIVE;
                        r_idx     <= '0;
                        r_wdog    <= '0;
                        r_begin   <= ONE;
                        r_enabler <= 1'b1;
                        r_cur     <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (!run) begin
                        // Abort wins over any handoff in the same cycle.
                        r_state   <= S_IDLE;
                        r_idx     <= '0;
                        r_wdog    <= '0;
                        r_begin   <= '0;
                        r_enabler <= 1'b0;
                        r_led     <= LED_IDLE;
                        r_cur     <= '0;
                    end else begin
                        r_led <= w_slice;
                        if (w_exp) begin
                            r_fault <= 1'b1;
                        end
                        if (w_hand) begin
                            r_wdog <= '0;
                            if (r_idx == LAST) begin
                                r_pass_done <= 1'b1;
                                r_idx       <= '0;
                                r_cur       <= '0;
                                if (loop_en) begin
                                    r_begin <= ONE;
                                end else begin
                                    r_state   <= S_DONE;
                                    r_begin   <= '0;
                                    r_enabler <= 1'b0;
                                    r_led     <= LED_IDLE;
                                end
                            end else begin
                                // Old begin drops, new begin rises together.
                                r_idx   <= w_nidx;
                                r_cur   <= w_nidx;
                                r_begin <= ONE << w_nidx;
                            end
                        end else begin
                            r_wdog <= r_wdog + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign st_begin  = r_begin;
    assign enabler   = r_enabler;
    assign led       = r_led;
    assign cur_st    = r_cur;
    assign pass_done = r_pass_done;
    assign fault     = r_fault;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: scenario tasks driving led_seq_ctrl against a
// cycle-level reference model of the stage sequencing rules.
module tb_led_seq_ctrl;

    localparam int NS = 4;
    localparam int LW = 18;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              sync_rs = 1'b1;
    logic              run = 1'b0;
    logic              loop_en = 1'b0;
    logic [NS-1:0]     st_over = '0;
    logic [NS*LW-1:0]  st_out = '0;
    logic [NS-1:0]     st_begin;
    logic              enabler;
    logic [LW-1:0]     led;
    logic [2:0]        cur_st;
    logic              pass_done;
    logic              fault;

    led_seq_ctrl #(
        .NUM_ST(NS),
        .LED_W(LW),
        .TIMEOUT(TO),
        .LED_IDLE(18'h00000)
    ) dut (
        .clk(clk),
        .sync_rs(sync_rs),
        .run(run),
        .loop_en(loop_en),
        .st_over(st_over),
        .st_out(st_out),
        .st_begin(st_begin),
        .enabler(enabler),
        .led(led),
        .cur_st(cur_st),
        .pass_done(pass_done),
        .fault(fault)
    );

    int total = 0;
    int bad = 0;

    // model: mode 0=idle 1=sequencing 2=finished; stage; cycles in stage
    int mm = 0;
    int ms = 0;
    int mt = 0;
    bit mf = 1'b0;

    logic [NS-1:0] e_begin;
    logic          e_en;
    logic [LW-1:0] e_led;
    logic [2:0]    e_cur;
    logic          e_pd;
    logic          e_fault;

    task automatic rnd_out();
        st_out = 72'({$urandom, $urandom, $urandom});
    endtask

    task automatic step();
        logic [LW-1:0] sl;
        sl = st_out[ms*LW +: LW];
        e_pd = 1'b0;
        e_led = '0;
        if (sync_rs) begin
            mm = 0; ms = 0; mt = 0; mf = 1'b0;
        end else if (mm == 0) begin
            if (run) begin
                mm = 1; ms = 0; mt = 0;
            end
        end else if (mm == 1) begin
            if (!run) begin
                mm = 0; ms = 0; mt = 0;
            end else begin
                e_led = sl;
                if (st_over[ms] || mt == TO - 1) begin
                    if (mt == TO - 1) mf = 1'b1;
                    mt = 0;
                    if (ms < NS - 1) begin
                        ms++;
                    end else begin
                        e_pd = 1'b1;
                        ms = 0;
                        if (!loop_en) mm = 2;
                    end
                end else begin
                    mt++;
                end
            end
        end else if (!run) begin
            mm = 0;
        end
        if (mm != 1) e_led = '0;
        e_begin = (mm == 1) ? NS'(1 << ms) : '0;
        e_en = (mm == 1);
        e_cur = (mm == 1) ? 3'(ms) : 3'd0;
        e_fault = mf;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sync_rs = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({st_begin, enabler, led, cur_st, pass_done, fault} !== 28'h0) begin
                bad++;
                $display("FAIL reset got=%h exp=0",
                         {st_begin, enabler, led, cur_st, pass_done, fault});
            end
        end
        sync_rs = 1'b0;
        step();
        total++;
        if (st_begin !== 4'b0001 || enabler !== 1'b1) begin
            bad++;
            $display("FAIL reset_start got beg=%b en=%b exp beg=0001 en=1",
                     st_begin, enabler);
        end
    endtask

    task automatic test_normal();
        int npd = 0;
        run = 1'b0;
        loop_en = 1'b0;
        step();
        run = 1'b1;
        step();
        for (int c = 1; c <= 45; c++) begin
            st_over = (c % 10 == 0 && c <= 40) ? NS'(1 << (c / 10 - 1)) : '0;
            rnd_out();
            step();
            if (pass_done) npd++;
            total++;
            if ({st_begin, enabler, led, cur_st, pass_done, fault} !==
                {e_begin, e_en, e_led, e_cur, e_pd, e_fault}) begin
                bad++;
                $display("FAIL normal c=%0d got=%h exp=%h", c,
                         {st_begin, enabler, led, cur_st, pass_done, fault},
                         {e_begin, e_en, e_led, e_cur, e_pd, e_fault});
            end
        end
        st_over = '0;
        total++;
        if (npd != 1 || st_begin !== 4'b0000 || led !== 18'h0 || enabler !== 1'b0) begin
            bad++;
            $display("FAIL normal_done got pd=%0d beg=%b led=%h exp pd=1 beg=0 led=0",
                     npd, st_begin, led);
        end
    endtask

    task automatic test_loop();
        int npd = 0;
        bit dropped = 1'b0;
        run = 1'b0;
        step();
        loop_en = 1'b1;
        run = 1'b1;
        step();
        for (int c = 1; c <= 85; c++) begin
            st_over = (c % 10 == 0) ? NS'(1 << ((c / 10 - 1) % 4)) : '0;
            rnd_out();
            step();
            if (pass_done) npd++;
            if (!enabler) dropped = 1'b1;
            total++;
            if ({st_begin, enabler, led, cur_st, pass_done, fault} !==
                {e_begin, e_en, e_led, e_cur, e_pd, e_fault}) begin
                bad++;
                $display("FAIL loop c=%0d got=%h exp=%h", c,
                         {st_begin, enabler, led, cur_st, pass_done, fault},
                         {e_begin, e_en, e_led, e_cur, e_pd, e_fault});
            end
        end
        st_over = '0;
        total++;
        if (npd != 2 || dropped) begin
            bad++;
            $display("FAIL loop_sum got pd=%0d drop=%0d exp pd=2 drop=0", npd, dropped);
        end
    endtask

    task automatic test_watchdog();
        int first_f = -1;
        sync_rs = 1'b1;
        step();
        sync_rs = 1'b0;
        run = 1'b0;
        step();
        loop_en = 1'b1;
        st_over = '0;
        run = 1'b1;
        step();
        for (int c = 1; c <= 70; c++) begin
            rnd_out();
            step();
            if (fault && first_f < 0) first_f = c;
            total++;
            if ({st_begin, enabler, led, cur_st, pass_done, fault} !==
                {e_begin, e_en, e_led, e_cur, e_pd, e_fault}) begin
                bad++;
                $display("FAIL wdog c=%0d got=%h exp=%h", c,
                         {st_begin, enabler, led, cur_st, pass_done, fault},
                         {e_begin, e_en, e_led, e_cur, e_pd, e_fault});
            end
        end
        total++;
        if (first_f != TO || fault !== 1'b1) begin
            bad++;
            $display("FAIL wdog_fault got first=%0d f=%b exp first=%0d f=1",
                     first_f, fault, TO);
        end
    endtask

    task automatic test_abort();
        run = 1'b0;
        loop_en = 1'b0;
        step();
        run = 1'b1;
        step();
        st_over = '1;
        step();
        step();
        st_over = '0;
        total++;
        if (st_begin !== 4'b0100 || st_begin !== e_begin) begin
            bad++;
            $display("FAIL abort_pre got beg=%b exp beg=0100", st_begin);
        end
        run = 1'b0;
        step();
        total++;
        if ({st_begin, enabler, led, cur_st, pass_done} !== 27'h0) begin
            bad++;
            $display("FAIL abort got=%h exp=0",
                     {st_begin, enabler, led, cur_st, pass_done});
        end
        run = 1'b1;
        step();
        total++;
        if (st_begin !== 4'b0001 || cur_st !== 3'd0 || enabler !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart got beg=%b cur=%0d exp beg=0001 cur=0",
                     st_begin, cur_st);
        end
    endtask

    task automatic test_spurious();
        st_over = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (cur_st !== 3'd0 || st_begin !== 4'b0001) begin
                bad++;
                $display("FAIL spurious got cur=%0d beg=%b exp cur=0 beg=0001",
                         cur_st, st_begin);
            end
        end
        st_over = '0;
        rnd_out();
        st_out[LW-1:0] = 18'h2AAAA;
        step();
        total++;
        if (led !== 18'h2AAAA || led !== e_led) begin
            bad++;
            $display("FAIL mux got led=%h exp led=2aaaa", led);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            sync_rs = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 19) == 0) loop_en = ~loop_en;
            for (int b = 0; b < NS; b++) st_over[b] = ($urandom_range(0, 7) == 0);
            rnd_out();
            step();
            total++;
            if ({st_begin, enabler, led, cur_st, pass_done, fault} !==
                {e_begin, e_en, e_led, e_cur, e_pd, e_fault}) begin
                bad++;
                $display("FAIL random c=%0d got=%h exp=%h", c,
                         {st_begin, enabler, led, cur_st, pass_done, fault},
                         {e_begin, e_en, e_led, e_cur, e_pd, e_fault});
            end
        end
        sync_rs = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_loop();
        test_watchdog();
        test_abort();
        test_spurious();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
